// File: rtl/alu_host_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_host_seq
// Description : Request/response host sequencer for a byte-serial ALU.
//               Latches a 2-bit opcode and two 32-bit operands, streams them
//               to the ALU a byte at a time (LSB first) and collects a 32-bit
//               result in four bytes before presenting it to the client.
//               Optional WAIT watchdog enabled by macro ALU_HOST_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_host_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic [7:0]  alu_in,
  output logic [1:0]  alu_opcode,
  output logic        alu_start,
  input  logic [7:0]  alu_out,
  input  logic        alu_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SEND_A = 3'd2,
    S_SEND_B = 3'd3,
    S_WAIT   = 3'd4,
    S_RECV   = 3'd5,
    S_RESP   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic [1:0]  r_idx;        // byte index shared by SEND_A, SEND_B and RECV
  logic        w_accept;
  logic        w_wd_expired;

  assign w_accept = req_valid && (r_state == S_IDLE);

`ifdef ALU_HOST_TIMEOUT_EN
  localparam logic [15:0] C_WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wd_cnt;
  logic        r_timeout;

  // Watchdog counter: zero outside WAIT so every WAIT entry starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= 16'd0;
    end else if (r_state != S_WAIT) begin
      r_wd_cnt <= 16'd0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  // A done arriving in the last allowed WAIT cycle still wins over the timeout.
  assign w_wd_expired = (r_state == S_WAIT) && !alu_done && (r_wd_cnt == C_WD_LAST);

  // Timeout flag: cleared by each new request, set when the watchdog fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_timeout <= 1'b0;
    end else if (w_wd_expired) begin
      r_timeout <= 1'b1;
    end
  end

  assign rsp_timeout = r_timeout;
`else
  // No watchdog: WAIT lasts until the ALU reports done.
  assign w_wd_expired = 1'b0;
  assign rsp_timeout  = 1'b0;

  // Parameter kept for interface compatibility; an illegal zero builds nothing.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    rsp_valid   = 1'b0;
    alu_start   = 1'b0;
    alu_opcode  = 2'd0;
    alu_in      = 8'h00;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_state_nxt = S_START;
      end
      S_START: begin
        alu_start   = 1'b1;
        alu_opcode  = r_op;
        w_state_nxt = S_SEND_A;
      end
      S_SEND_A: begin
        alu_opcode = r_op;
        alu_in     = r_a[{r_idx, 3'b000} +: 8];
        if (r_idx == 2'd3) w_state_nxt = S_SEND_B;
      end
      S_SEND_B: begin
        alu_opcode = r_op;
        alu_in     = r_b[{r_idx, 3'b000} +: 8];
        if (r_idx == 2'd3) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        alu_opcode = r_op;
        if (alu_done) begin
          w_state_nxt = S_RECV;
        end else if (w_wd_expired) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RECV: begin
        alu_opcode = r_op;
        if (r_idx == 2'd3) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand latch, byte index and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 2'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
      r_idx    <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op     <= req_opcode;
            r_a      <= req_a;
            r_b      <= req_b;
            r_result <= 32'd0;
            r_idx    <= 2'd0;
          end
        end
        S_START: begin
          r_idx <= 2'd0;
        end
        S_SEND_A, S_SEND_B: begin
          r_idx <= r_idx + 2'd1;
        end
        S_WAIT: begin
          if (alu_done) begin
            r_result[7:0] <= alu_out;
            r_idx         <= 2'd1;
          end
        end
        S_RECV: begin
          r_result[{r_idx, 3'b000} +: 8] <= alu_out;
          r_idx                          <= r_idx + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_host_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_host_seq
// Description : Self-checking bench for alu_host_seq with a cycle-indexed
//               reference of the byte protocol and a responding ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_host_seq;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_timeout;
  logic [7:0]  alu_in;
  logic [1:0]  alu_opcode;
  logic        alu_start;
  logic [7:0]  alu_out;
  logic        alu_done;
  logic        busy;

  int tests;
  int fails;

  alu_host_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_timeout(rsp_timeout),
    .alu_in     (alu_in),
    .alu_opcode (alu_opcode),
    .alu_start  (alu_start),
    .alu_out    (alu_out),
    .alu_done   (alu_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs every output into one word so idle/reset checks are a single compare.
  function automatic logic [47:0] outs_word();
    return {req_ready, busy, rsp_valid, rsp_timeout, alu_start, alu_opcode, alu_in, rsp_result, 1'b0};
  endfunction

  localparam logic [47:0] C_IDLE_OUTS = {1'b1, 47'd0};

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_opcode = 2'd0; req_a = 32'd0; req_b = 32'd0;
    rsp_ready = 1'b0; alu_out = 8'd0; alu_done = 1'b0;
    #12;
    tests++;
    if (outs_word() !== C_IDLE_OUTS) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", outs_word(), C_IDLE_OUTS);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (outs_word() !== C_IDLE_OUTS) begin
      fails++;
      $display("FAIL reset_release_idle: got %h expected %h", outs_word(), C_IDLE_OUTS);
    end
  endtask

  // One full request. Cycle k counts from the accepting edge: k=1 START,
  // 2..5 operand A bytes, 6..9 operand B bytes, 10.. WAIT. The model ALU
  // raises done at cycle 10+delay with result byte 0, then streams bytes 1..3.
  // delay < 0 means done is never raised.
  task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] word, input int delay, input int hold,
                         input bit noisy, input string tag);
    int          k;
    int          dk;
    int          resp_k;
    int          max_k;
    logic [31:0] exp_res;
    logic        exp_to;
    logic [7:0]  exp_in;
    logic [1:0]  exp_op;
    logic        exp_start;

    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s/ready_wait: got %b expected 1", tag, req_ready);
    end

    exp_res = word;
    exp_to  = 1'b0;
    resp_k  = 14 + delay;
    max_k   = resp_k;
    if (delay < 0) begin
`ifdef ALU_HOST_TIMEOUT_EN
      resp_k  = 10 + TO;
      max_k   = resp_k;
      exp_res = 32'd0;
      exp_to  = 1'b1;
`else
      resp_k  = 0;
      max_k   = 1000;
`endif
    end

    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    if (!noisy) req_valid = 1'b0;

    for (k = 1; k < max_k; k++) begin
      exp_start = (k == 1);
      exp_op    = op;
      if (k >= 2 && k <= 5)      exp_in = a[8*(k-2) +: 8];
      else if (k >= 6 && k <= 9) exp_in = b[8*(k-6) +: 8];
      else                       exp_in = 8'h00;

      tests++;
      if ({req_ready, busy, rsp_valid} !== 3'b010) begin
        fails++;
        $display("FAIL %s/handshake_k%0d: got %b expected 010", tag, k, {req_ready, busy, rsp_valid});
      end
      tests++;
      if (alu_start !== exp_start) begin
        fails++;
        $display("FAIL %s/alu_start_k%0d: got %b expected %b", tag, k, alu_start, exp_start);
      end
      tests++;
      if (alu_opcode !== exp_op) begin
        fails++;
        $display("FAIL %s/alu_opcode_k%0d: got %0d expected %0d", tag, k, alu_opcode, exp_op);
      end
      tests++;
      if (alu_in !== exp_in) begin
        fails++;
        $display("FAIL %s/alu_in_k%0d: got %h expected %h", tag, k, alu_in, exp_in);
      end

      // Model ALU drive for this cycle.
      alu_done = 1'b0;
      alu_out  = 8'($urandom);
      if (delay >= 0) begin
        dk = k - (10 + delay);
        if (dk >= 0 && dk <= 3) begin
          alu_out = word[8*dk +: 8];
          if (dk == 0)    alu_done = 1'b1;
          else if (noisy) alu_done = 1'($urandom);
        end
      end
      if (noisy && (k == 3 || k == 7)) alu_done = 1'b1;
      if (noisy) begin
        req_a = $urandom; req_b = $urandom; req_opcode = 2'($urandom);
      end
      @(posedge clk); #1;
    end
    alu_done = 1'b0;

    if (resp_k == 0) begin
      // Watchdog absent: design must still be waiting; recover with reset.
      tests++;
      if ({busy, rsp_valid} !== 2'b10) begin
        fails++;
        $display("FAIL %s/still_wait: got %b expected 10", tag, {busy, rsp_valid});
      end
      req_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (outs_word() !== C_IDLE_OUTS) begin
        fails++;
        $display("FAIL %s/recover: got %h expected %h", tag, outs_word(), C_IDLE_OUTS);
      end
      return;
    end

    tests++;
    if ({req_ready, busy, rsp_valid, alu_start, alu_opcode, alu_in} !== {3'b011, 1'b0, 2'd0, 8'h00}) begin
      fails++;
      $display("FAIL %s/resp_ctrl: got %b expected 011000000000000", tag,
               {req_ready, busy, rsp_valid, alu_start, alu_opcode, alu_in});
    end
    tests++;
    if (rsp_result !== exp_res) begin
      fails++;
      $display("FAIL %s/rsp_result: got %h expected %h", tag, rsp_result, exp_res);
    end
    tests++;
    if (rsp_timeout !== exp_to) begin
      fails++;
      $display("FAIL %s/rsp_timeout: got %b expected %b", tag, rsp_timeout, exp_to);
    end

    for (int j = 0; j < hold; j++) begin
      alu_done = 1'($urandom);
      @(posedge clk); #1;
      tests++;
      if ({rsp_valid, rsp_timeout, rsp_result} !== {1'b1, exp_to, exp_res}) begin
        fails++;
        $display("FAIL %s/hold_%0d: got %b/%b/%h expected 1/%b/%h", tag, j,
                 rsp_valid, rsp_timeout, rsp_result, exp_to, exp_res);
      end
    end
    alu_done = 1'b0;

    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    tests++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      fails++;
      $display("FAIL %s/exit_idle: got %b expected 100", tag, {req_ready, busy, rsp_valid});
    end
  endtask

  task automatic test_directed();
    run_txn(2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 1'b0, "directed_min");
    run_txn(2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 20, 5, 1'b0, "directed_stall");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_txn(2'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 6)),
              int'($urandom_range(0, 3)), 1'b0, $sformatf("random_%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      run_txn(2'($urandom), $urandom, $urandom, $urandom, 0, 0, 1'b0, $sformatf("b2b_%0d", i));
    end
  endtask

  task automatic test_busy_noise();
    run_txn(2'd3, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 2, 1, 1'b1, "noise_0");
    run_txn(2'($urandom), $urandom, $urandom, $urandom, 4, 0, 1'b1, "noise_1");
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_opcode = 2'd2; req_a = $urandom; req_b = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Advance from cycle 1 (START) to cycle 8 (third byte of operand B).
    repeat (7) begin
      @(posedge clk); #1;
    end
    tests++;
    if (alu_in !== req_b[23:16]) begin
      fails++;
      $display("FAIL reset_mid/pre_byte: got %h expected %h", alu_in, req_b[23:16]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (outs_word() !== C_IDLE_OUTS) begin
      fails++;
      $display("FAIL reset_mid/async_outputs: got %h expected %h", outs_word(), C_IDLE_OUTS);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(2'd1, 32'hCAFE_F00D, 32'h1234_5678, 32'h5555_AAAA, 1, 2, 1'b0, "after_reset");
  endtask

  task automatic test_timeout();
    run_txn(2'd1, $urandom, $urandom, $urandom, -1, 2, 1'b0, "timeout");
    run_txn(2'd2, $urandom, $urandom, $urandom, 3, 0, 1'b0, "post_timeout");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_noise();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_host_seq.md
ALU_HOST_SEQ -- requirements
Module: alu_host_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum WAIT cycles before timeout (range 1..65535).
REQ-002 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  client request present.
REQ-005 req_ready  output  1  high only in IDLE; request accepted when req_valid&&req_ready.
REQ-006 req_opcode  input  2  ALU operation code.
REQ-007 req_a, req_b  input  32 each  IEEE-754 single operands.
REQ-008 rsp_valid  output  1  response present; held until rsp_ready.
REQ-009 rsp_ready  input  1  client accepts response.
REQ-010 rsp_result  output  32  assembled ALU result.
REQ-011 rsp_timeout  output  1  response ended by watchdog, not done.
REQ-012 alu_in  output  8  operand byte to ALU in bus.
REQ-013 alu_opcode  output  2  to ALU opcode pins.
REQ-014 alu_start  output  1  to ALU start pin.
REQ-015 alu_out  input  8  result byte from ALU out bus.
REQ-016 alu_done  input  1  ALU done flag.
REQ-017 busy  output  1  high in any state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, START, SEND_A, SEND_B, WAIT, RECV, RESP.
REQ-019 IDLE: on accept, latch opcode/A/B, go START next cycle.
REQ-020 START: exactly one cycle alu_start=1, alu_in=0x00, alu_opcode=latched opcode.
REQ-021 SEND_A: 4 cycles, alu_in = A[7:0], A[15:8], A[23:16], A[31:24] in order; SEND_B likewise for B.
REQ-022 alu_opcode SHALL hold the latched opcode from START through end of RECV; 0 otherwise.
REQ-023 alu_in SHALL be 0x00 in every state except SEND_A/SEND_B.
REQ-024 WAIT: first cycle alu_done sampled high, capture alu_out as result[7:0], go RECV.
REQ-025 RECV: next 3 cycles capture alu_out as result[15:8], [23:16], [31:24]; then RESP (alu_done ignored in RECV).
REQ-026 alu_done high outside WAIT SHALL be ignored.
REQ-027 RESP: rsp_valid=1, rsp_result/rsp_timeout stable; on rsp_ready high go IDLE next cycle.
REQ-028 Minimum request-to-rsp_valid latency with done in first WAIT cycle: 14 cycles (1 START + 8 send + 1 WAIT + 3 RECV + 1).
REQ-029 req_valid while busy SHALL NOT be accepted nor alter latched operands.
REQ-030 Back-to-back: accept permitted the cycle after RESP exits (req_ready high in IDLE).

Reset
REQ-031 rst_n low SHALL immediately force IDLE and all outputs to 0 except req_ready=1, regardless of current state (including mid-SEND or mid-RECV).
REQ-032 Latched operands, result, and timeout counter SHALL clear to 0 on reset.

Configuration
REQ-033 Macro ALU_HOST_TIMEOUT_EN defined: WAIT counter increments each cycle; reaching TIMEOUT_CYCLES without done SHALL go RESP with rsp_result=0, rsp_timeout=1; counter clears on WAIT entry.
REQ-034 Macro undefined: no counter, WAIT indefinite, rsp_timeout tied 0, TIMEOUT_CYCLES unused.

Verification
REQ-035 op=0, A=0x3F800000, B=0x40000000, model done after 1 WAIT cycle streaming 00,00,40,40 -> alu_in sequence 00,00,80,3F,00,00,00,40; rsp_result=0x40400000, rsp_timeout=0, rsp_valid at cycle 14.
REQ-036 Same request, done delayed 20 cycles, rsp_ready held low 5 cycles -> rsp_valid/rsp_result stable 5 cycles, IDLE one cycle after rsp_ready.
REQ-037 With ALU_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=8, done never asserted -> RESP after 8 WAIT cycles, rsp_result=0, rsp_timeout=1; without macro -> still in WAIT after 1000 cycles.
REQ-038 rst_n pulsed low during SEND_B byte 2 -> outputs zero, req_ready=1 same cycle; subsequent request completes correctly.
REQ-039 req_valid held high with changing req_a while busy, alu_done pulsed during SEND_A -> only first operands transmitted, spurious done ignored.
